// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Start handshake, direct-write and HI/LO result bundle for the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_valid, op, a, b, flush, hi_we, lo_we, wdata,
        input  start_ready, busy, done, hi, lo
    );

    modport slave (
        input  start_valid, op, a, b, flush, hi_we, lo_we, wdata,
        output start_ready, busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative signed/unsigned multiply (shift-add) and divide
//            (restoring) with architectural HI/LO registers.
//            Optional: MULDIV_EARLY_OUT_EN skips iteration when b == 0.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    muldiv_unit_if.slave     mdu
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_fire;
    logic               w_early;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign mdu.start_ready = (r_state == S_IDLE) && !mdu.flush;
    assign mdu.busy        = r_busy;
    assign mdu.done        = r_done;
    assign mdu.hi          = r_hi;
    assign mdu.lo          = r_lo;

    assign w_fire  = mdu.start_valid && mdu.start_ready;
    assign w_a_neg = !mdu.op[0] && mdu.a[WIDTH-1];
    assign w_b_neg = !mdu.op[0] && mdu.b[WIDTH-1];
    assign w_amag  = w_a_neg ? -mdu.a : mdu.a;
    assign w_bmag  = w_b_neg ? -mdu.b : mdu.b;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (mdu.b == '0);
`else
    assign w_early = 1'b0;
`endif

    // One iteration: multiply adds then shifts right; divide shifts left then trial-subtracts.
    assign w_sum   = r_mq[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;
    assign w_shift = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_mcand};

    always_comb begin
        w_acc_nxt = r_acc;
        w_mq_nxt  = r_mq;
        if (!r_op[1]) begin
            w_acc_nxt = {1'b0, w_sum[WIDTH:1]};
            w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
        end else if (!w_diff[WIDTH+1]) begin
            w_acc_nxt = w_diff[WIDTH:0];
            w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_nxt = w_shift;
            w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
        end
    end

    // Divide by zero leaves |a| in the remainder, so restoring its sign yields hi = a.
    assign w_prod   = {r_acc[WIDTH-1:0], r_mq};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_rem    = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_hi_res = r_op[1] ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_lo_res = !r_op[1] ? w_prod_s[WIDTH-1:0] :
                      r_dbz    ? '1 :
                      r_neg_q  ? -r_mq : r_mq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (mdu.hi_we) r_hi <= mdu.wdata;
                if (mdu.lo_we) r_lo <= mdu.wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_op    <= mdu.op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dbz   <= mdu.op[1] && (mdu.b == '0);
                        r_cnt   <= c_cnt_init;
                        r_acc   <= (w_early && mdu.op[1]) ? {1'b0, w_amag} : '0;
                        r_mq    <= mdu.op[1] ? w_amag : w_bmag;
                        r_mcand <= mdu.op[1] ? w_bmag : w_amag;
                        r_busy  <= 1'b1;
                        r_state <= w_early ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (mdu.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_mq  <= w_mq_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!mdu.flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int WIDTH = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int c_zero_lat = 2;
`else
    localparam int c_zero_lat = WIDTH + 2;
`endif
    localparam int c_lat = WIDTH + 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    muldiv_unit_if #(.WIDTH(WIDTH)) mdu ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, scrambles operands after the handshake, then checks
    // latency, busy window and the HI/LO result. Ends in the done cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
        int cyc;
        int busy_bad;
        mdu.start_valid = 1'b1;
        mdu.op          = o;
        mdu.a           = x;
        mdu.b           = y;
        #1;
        check_eq({tag, "_ready"}, 64'(mdu.start_ready), 64'd1);
        step();
        mdu.start_valid = 1'b0;
        mdu.op          = ~o;
        mdu.a           = $urandom;
        mdu.b           = $urandom;
        cyc      = 1;
        busy_bad = 0;
        while (!mdu.done && cyc < 100) begin
            if (mdu.busy !== 1'b1) busy_bad++;
            step();
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'(elat));
        check_eq({tag, "_busywin"}, 64'(busy_bad), 64'd0);
        check_eq({tag, "_busydone"}, 64'(mdu.busy), 64'd0);
        check_eq({tag, "_hi"}, 64'(mdu.hi), 64'(ehi));
        check_eq({tag, "_lo"}, 64'(mdu.lo), 64'(elo));
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        mdu.hi_we = 1'b1;
        mdu.wdata = h;
        step();
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b1;
        mdu.wdata = l;
        step();
        mdu.lo_we = 1'b0;
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (mdu.done) seen++;
            step();
        end
    endtask

    task automatic start_only(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        mdu.start_valid = 1'b1;
        mdu.op          = o;
        mdu.a           = x;
        mdu.b           = y;
        step();
        mdu.start_valid = 1'b0;
    endtask

    initial begin
        int seen;
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        mdu.start_valid = 1'b0;
        mdu.op          = 2'b00;
        mdu.a           = '0;
        mdu.b           = '0;
        mdu.flush       = 1'b0;
        mdu.hi_we       = 1'b0;
        mdu.lo_we       = 1'b0;
        mdu.wdata       = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_eq("rst_hi", 64'(mdu.hi), 64'd0);
        check_eq("rst_lo", 64'(mdu.lo), 64'd0);
        check_eq("rst_busy", 64'(mdu.busy), 64'd0);
        check_eq("rst_done", 64'(mdu.done), 64'd0);
        check_eq("rst_ready", 64'(mdu.start_ready), 64'd1);

        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, c_lat);
        step();
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, c_lat);
        // Second start issued in the done cycle: completes at T+68 of the first.
        do_op("b2b_multu", 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, c_lat);
        do_op("mult_mix", 2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, c_lat);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, c_lat);
        do_op("divu_7_2", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, c_lat);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, c_lat);
        do_op("div_negdiv", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, c_lat);
        do_op("divu_zero", 2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, c_zero_lat);
        do_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, c_zero_lat);
        do_op("mult_zero", 2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, c_zero_lat);

        // Flush at T+10 discards the multiply.
        write_hilo(32'hAAAA_0000, 32'h0000_BBBB);
        start_only(2'b00, 32'h0000_0003, 32'h0000_0005);
        repeat (9) step();
        mdu.flush = 1'b1;
        step();
        mdu.flush = 1'b0;
        check_eq("flush_busy", 64'(mdu.busy), 64'd0);
        count_done(40, seen);
        check_eq("flush_nodone", 64'(seen), 64'd0);
        check_eq("flush_hi", 64'(mdu.hi), 64'hAAAA_0000);
        check_eq("flush_lo", 64'(mdu.lo), 64'h0000_BBBB);

        // Asynchronous reset at T+10 clears HI/LO immediately.
        start_only(2'b00, 32'h0000_0003, 32'h0000_0005);
        repeat (9) step();
        rst = 1'b1;
        #1;
        check_eq("arst_hi", 64'(mdu.hi), 64'd0);
        check_eq("arst_lo", 64'(mdu.lo), 64'd0);
        check_eq("arst_busy", 64'(mdu.busy), 64'd0);
        step();
        rst = 1'b0;
        count_done(40, seen);
        check_eq("arst_nodone", 64'(seen), 64'd0);

        // Write alongside an accepted start lands; write while busy is dropped.
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h0000_0077;
        start_only(2'b11, 32'h0000_0007, 32'h0000_0002);
        mdu.lo_we = 1'b0;
        check_eq("hs_write_lo", 64'(mdu.lo), 64'h0000_0077);
        step();
        mdu.hi_we = 1'b1;
        mdu.wdata = 32'h0000_0005;
        step();
        mdu.hi_we = 1'b0;
        check_eq("busy_write_hi", 64'(mdu.hi), 64'd0);
        seen = 0;
        while (!mdu.done && seen < 100) begin
            step();
            seen++;
        end
        check_eq("busy_write_done", 64'(mdu.done), 64'd1);
        check_eq("busy_write_res_hi", 64'(mdu.hi), 64'd1);
        check_eq("busy_write_res_lo", 64'(mdu.lo), 64'd3);
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h0000_0009;
        step();
        mdu.lo_we = 1'b0;
        check_eq("idle_write_lo", 64'(mdu.lo), 64'h0000_0009);
        check_eq("idle_write_hi", 64'(mdu.hi), 64'd1);

        // Flush in IDLE blocks the start.
        mdu.start_valid = 1'b1;
        mdu.flush       = 1'b1;
        mdu.op          = 2'b01;
        mdu.a           = 32'h0000_0002;
        mdu.b           = 32'h0000_0002;
        #1;
        check_eq("idle_flush_ready", 64'(mdu.start_ready), 64'd0);
        step();
        mdu.start_valid = 1'b0;
        mdu.flush       = 1'b0;
        check_eq("idle_flush_busy", 64'(mdu.busy), 64'd0);
        count_done(40, seen);
        check_eq("idle_flush_nodone", 64'(seen), 64'd0);
        check_eq("idle_flush_lo", 64'(mdu.lo), 64'h0000_0009);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit with architectural HI/LO result registers, sitting beside the single-cycle arithmetic unit in the execute stage. It handles signed and unsigned multiply and divide at a parametrised data width, producing a 2×WIDTH product or a quotient/remainder pair. Operands enter through a valid/ready start handshake, and a one-cycle done pulse marks completion. HI/LO stay readable at all times and can be written directly for move-to-HI/LO instructions.

## Interface
- WIDTH, 32, operand and HI/LO register width; must be ≥ 4.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_valid  in  1  request to start an operation.
- start_ready  out  1  high when a start is accepted this cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, b  in  WIDTH  operands: multiplicand/multiplier, or dividend/divisor.
- flush  in  1  synchronous abort of any operation in flight.
- hi_we, lo_we  in  1  direct-write enables for HI and LO.
- wdata  in  WIDTH  direct-write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi, lo  out  WIDTH  HI/LO register contents.

## Operation
- FSM states:
  - IDLE: `start_ready` = !flush. A handshake (`start_valid` && `start_ready`) latches the operand magnitudes, the result sign flags and the op, loads counter = WIDTH, then moves to CALC.
  - CALC: processes one bit per cycle; radix-2 shift-add for multiply, restoring shift-subtract for divide. Counter decrements each cycle; at 0 the FSM moves to FIX.
  - FIX: applies two's-complement sign correction (signed ops only), writes HI/LO, sets `done` for the next cycle, then returns to IDLE.
- Results:
  - Multiply: {hi, lo} = full 2×WIDTH product.
  - Divide: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Divide by zero: hi = a, lo = all ones, for both DIV and DIVU. No exception is raised.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- Direct writes: `hi_we`/`lo_we` update HI/LO on the clock edge only while `busy` = 0; writes while busy are ignored. A write in the same cycle as an accepted start takes effect; the later FIX then overwrites it.
- `flush`:
  - In CALC or FIX: return to IDLE next cycle, no HI/LO update, no `done`.
  - In IDLE: blocks the start, since `start_ready` = 0.
- Reset values: state IDLE, `busy` 0, `done` 0, hi 0, lo 0, counter 0, internal datapath 0. `start_ready` is 1 once reset deasserts. Reset mid-operation discards the operation without a `done`.

## Timing
- Let T be the handshake cycle.
- `busy` is high from T+1 through the FIX cycle: T+WIDTH+1 for full latency.
- HI/LO update at the end of FIX.
- `done` = 1 and new HI/LO are visible at T+WIDTH+2 (T+34 for WIDTH = 32). In that cycle the FSM is in IDLE and a new start may be accepted.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- All outputs are registered except `start_ready` (combinational from state and `flush`).
- `start_valid`, `op`, `a` and `b` are sampled only at T; changes afterward have no effect.

## Configuration
- MULDIV_EARLY_OUT_EN defined: when b == 0 at handshake, the FSM skips CALC and goes directly to FIX.
  - Multiply result: 0/0.
  - Divide result: the divide-by-zero rule.
  - `done` at T+2, `busy` high only at T+1.
- Undefined: every operation takes full latency, including b == 0.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=0x00000007 -> at T+34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T+1..T+33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a second start accepted in the done cycle completes at T+68.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF. Done at T+34 without MULDIV_EARLY_OUT_EN, at T+2 with it.
- With prior hi=0xAAAA0000, lo=0x0000BBBB: start MULT; assert flush at T+10 -> busy=0 at T+11, done never asserts, HI/LO unchanged. Repeat with rst pulsed at T+10 -> hi=lo=0 immediately.
- hi_we with wdata=0x5 while busy -> hi unchanged. lo_we with wdata=0x9 while idle -> lo=0x9 next cycle. start_valid with flush=1 in IDLE -> start_ready=0, no operation starts.
